// File: rtl/tempsense_pkg.sv
// Shared definitions for the temperature-sensor VDAC control path.
package tempsense_pkg;

    localparam int unsigned N_VDAC_DEFAULT = 5;

    // Code limits shared with the sensor sequencer.
    localparam logic [N_VDAC_DEFAULT-1:0] VMAX_CODE = '1;
    localparam logic [N_VDAC_DEFAULT-1:0] VMIN_CODE = '0;

    typedef enum logic [1:0] {
        StIdle,
        StTrial,
        StUpdate,
        StDone
    } sar_state_e;

endpackage

// File: rtl/tempsense_sar_ctrl.sv
// SAR controller: binary search over the VDAC code, one sensor trial per bit,
// with optional averaging of 2^AVG_LOG2 conversions per result.
module tempsense_sar_ctrl
    import tempsense_pkg::*;
#(
    parameter int unsigned N_VDAC   = N_VDAC_DEFAULT,
    parameter int unsigned AVG_LOG2 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_continuous,
    output logic              o_trial_req,
    output logic [N_VDAC-1:0] o_dac_code,
    input  logic              i_trial_done,
    input  logic              i_cmp,
    output logic [N_VDAC-1:0] o_result,
    output logic              o_valid,
    output logic              o_busy
);

    localparam int unsigned       IdxW    = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
    localparam int unsigned       CntW    = AVG_LOG2 + 1;
    localparam int unsigned       AccW    = N_VDAC + AVG_LOG2;
    localparam logic [N_VDAC-1:0] MsbCode = N_VDAC'(1) << (N_VDAC - 1);
    localparam logic [IdxW-1:0]   MsbIdx  = IdxW'(N_VDAC - 1);
    localparam logic [CntW-1:0]   NumConv = CntW'(1) << AVG_LOG2;

    sar_state_e        state_q, state_d;
    logic [N_VDAC-1:0] code_q, code_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              last_q, last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [N_VDAC-1:0] result_q, result_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            code_q   <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        idx_d    = idx_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StTrial;
                    code_d  = MsbCode;
                    idx_d   = MsbIdx;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            StTrial: begin
                if (i_trial_done) begin
                    code_d[idx_q] = i_cmp;
                    if (idx_q != '0) begin
                        code_d[idx_q - 1'b1] = 1'b1;
                        idx_d                = idx_q - 1'b1;
                    end else begin
                        last_d = 1'b1;
                    end
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                last_d = 1'b0;
                if (last_q) begin
                    acc_d = acc_q + AccW'(code_q);
                    cnt_d = cnt_q + 1'b1;
                end
                // Result is registered here so it is already stable during DONE.
                if (cnt_d == NumConv) begin
                    state_d  = StDone;
                    result_d = N_VDAC'(acc_d >> AVG_LOG2);
                end else if (last_q) begin
                    state_d = StTrial;
                    code_d  = MsbCode;
                    idx_d   = MsbIdx;
                end else begin
                    state_d = StTrial;
                end
            end
            StDone: begin
                if (i_continuous) begin
                    state_d = StTrial;
                    code_d  = MsbCode;
                    idx_d   = MsbIdx;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_trial_req = (state_q == StTrial);
        o_valid     = (state_q == StDone);
        o_busy      = (state_q != StIdle);
        o_dac_code  = code_q;
        o_result    = result_q;
    end

endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
// Directed bench for tempsense_sar_ctrl: one instance without averaging, one averaging 4.
module tb_tempsense_sar_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start, cont, done, cmp;
    logic       req0, req2, valid0, valid2, busy0, busy2;
    logic [4:0] code0, code2, res0, res2;

    always #5 clk = ~clk;

    tempsense_sar_ctrl #(.N_VDAC(5), .AVG_LOG2(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start[0]),
        .i_continuous (cont[0]),
        .o_trial_req  (req0),
        .o_dac_code   (code0),
        .i_trial_done (done[0]),
        .i_cmp        (cmp[0]),
        .o_result     (res0),
        .o_valid      (valid0),
        .o_busy       (busy0)
    );

    tempsense_sar_ctrl #(.N_VDAC(5), .AVG_LOG2(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start[1]),
        .i_continuous (cont[1]),
        .o_trial_req  (req2),
        .o_dac_code   (code2),
        .i_trial_done (done[1]),
        .i_cmp        (cmp[1]),
        .o_result     (res2),
        .o_valid      (valid2),
        .o_busy       (busy2)
    );

    int total = 0;
    int bad   = 0;
    int thr[4];
    int tlog[$];
    int vcnt[2];
    int vres[2];
    int vtimes[$];
    int cyc = 0;
    int idle_cnt = 0;
    bit track_idle = 1'b0;

    int exp13[5] = '{16, 8, 12, 14, 13};
    int exp0[5]  = '{16, 8, 4, 2, 1};
    int exp31[5] = '{16, 24, 28, 30, 31};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic f_req(input int d);
        return (d == 0) ? req0 : req2;
    endfunction

    function automatic int f_code(input int d);
        return (d == 0) ? int'(code0) : int'(code2);
    endfunction

    // Outputs are all registered, so sampling at negedge is race-free with input drives.
    always @(negedge clk) begin
        cyc++;
        if (valid0) begin
            vcnt[0]++;
            vres[0] = int'(res0);
            vtimes.push_back(cyc);
        end
        if (valid2) begin
            vcnt[1]++;
            vres[1] = int'(res2);
        end
        if (track_idle && !busy0) idle_cnt++;
    end

    task automatic kick(input int d);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    // Sensor model: i_cmp = (code <= threshold of the current conversion).
    task automatic serve(input int d, input int first, input int n, input bit dly,
                         input bit disturb);
        for (int k = first; k < first + n; k++) begin
            int w = 0;
            while (!f_req(d) && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!f_req(d)) begin
                check("req_timeout", 32'(f_req(d)), 32'd1);
                return;
            end
            if (dly) @(negedge clk);
            tlog.push_back(f_code(d));
            cmp[d]  = (f_code(d) <= thr[k / 5]);
            done[d] = 1'b1;
            @(negedge clk);
            done[d] = 1'b0;
            cmp[d]  = 1'b0;
            if (disturb) begin
                start[d] = 1'b1;
                done[d]  = 1'b1;
                cmp[d]   = 1'b1;
                @(negedge clk);
                start[d] = 1'b0;
                done[d]  = 1'b0;
                cmp[d]   = 1'b0;
            end
        end
    endtask

    task automatic check_codes(input string tag, input int e[5]);
        check({tag, "_ntrials"}, tlog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_code%0d", tag, i), tlog[i], e[i]);
        end
    endtask

    task automatic run_single(input string tag, input int t, input int e[5], input bit disturb);
        thr[0] = t;
        tlog.delete();
        vcnt[0] = 0;
        kick(0);
        serve(0, 0, 5, 1'b1, disturb);
        repeat (3) @(negedge clk);
        check_codes(tag, e);
        check({tag, "_result"}, vres[0], t);
        check({tag, "_vcnt"}, vcnt[0], 1);
        check({tag, "_busy_end"}, busy0, 0);
        check({tag, "_res_held"}, res0, t);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = '0;
        cont  = '0;
        done  = '0;
        cmp   = '0;
        vcnt  = '{0, 0};
        vres  = '{0, 0};
        thr   = '{0, 0, 0, 0};
        repeat (3) @(negedge clk);
        check("rst_req", req0, 0);
        check("rst_code", code0, 0);
        check("rst_result", res0, 0);
        check("rst_valid", valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_busy2", busy2, 0);
        reset = 1'b0;
        @(negedge clk);

        // Start latency: busy, request and MSB code one cycle after i_start.
        thr[0] = 13;
        tlog.delete();
        vcnt[0] = 0;
        kick(0);
        check("start_busy", busy0, 1);
        check("start_req", req0, 1);
        check("start_code", code0, 16);
        serve(0, 0, 5, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_codes("thr13", exp13);
        check("thr13_result", vres[0], 13);
        check("thr13_vcnt", vcnt[0], 1);
        check("thr13_busy_end", busy0, 0);

        run_single("thr0", 0, exp0, 1'b0);
        run_single("thr31", 31, exp31, 1'b0);

        // Averaging 4 conversions: 12+13+13+14 = 52, >>2 = 13.
        thr = '{12, 13, 13, 14};
        tlog.delete();
        vcnt[1] = 0;
        kick(1);
        serve(1, 0, 19, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("avg_no_early_valid", vcnt[1], 0);
        check("avg_busy_mid", busy2, 1);
        serve(1, 19, 1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("avg_ntrials", tlog.size(), 20);
        check("avg_last_code", tlog[19], 15);
        check("avg_vcnt", vcnt[1], 1);
        check("avg_result", vres[1], 13);
        check("avg_busy_end", busy2, 0);

        // Reset during the third trial.
        thr[0] = 13;
        tlog.delete();
        kick(0);
        serve(0, 0, 2, 1'b1, 1'b0);
        for (int w = 0; w < 20 && !req0; w++) @(negedge clk);
        check("mid_third_req", req0, 1);
        check("mid_third_code", code0, 12);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", req0, 0);
        check("mid_rst_code", code0, 0);
        check("mid_rst_result", res0, 0);
        check("mid_rst_valid", valid0, 0);
        check("mid_rst_busy", busy0, 0);
        reset = 1'b0;
        @(negedge clk);
        run_single("after_rst", 13, exp13, 1'b0);

        // Spurious start and done pulses while the request is low.
        run_single("disturb", 13, exp13, 1'b1);

        // Continuous mode with combinational done: a result every 11 cycles.
        thr = '{7, 7, 7, 7};
        tlog.delete();
        vtimes.delete();
        vcnt[0] = 0;
        cont[0] = 1'b1;
        kick(0);
        idle_cnt   = 0;
        track_idle = 1'b1;
        serve(0, 0, 15, 1'b0, 1'b0);
        track_idle = 1'b0;
        cont[0]    = 1'b0;
        repeat (3) @(negedge clk);
        check("cont_vcnt", vcnt[0], 3);
        check("cont_period01", vtimes[1] - vtimes[0], 11);
        check("cont_period12", vtimes[2] - vtimes[1], 11);
        check("cont_result", vres[0], 7);
        check("cont_idle_cycles", idle_cnt, 0);
        check("cont_busy_end", busy0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
